// File: rtl/mips_mem_pkg.sv
// ============================================================================
// Module      : mips_mem_pkg
// Description : Shared data-memory constants and the store-buffer entry type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_mem_pkg;

    localparam int SB_DEPTH = 4;
    localparam int DM_AW    = 10;
    localparam int DW       = 32;

    // One pending store: valid flag, word address, data and PC+8 for the write log.
    typedef struct packed {
        logic              valid;
        logic [DM_AW-1:0]  addr;
        logic [DW-1:0]     data;
        logic [31:0]       pc8;
    } sb_entry_t;

endpackage

`default_nettype wire

// File: rtl/dm_store_buffer_if.sv
// ============================================================================
// Module      : dm_store_buffer_if
// Description : Store, load-check and data-memory drain signals of the store
//               buffer. master = pipeline/memory side, slave = the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dm_store_buffer_if
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = DM_AW,
    parameter int DW    = mips_mem_pkg::DW
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic [31:0]   st_pc8;
    logic          st_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_fwd;
    logic [DW-1:0] ld_data;
    logic          ld_stall;
    logic          drain_ok;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_data;
    logic [31:0]   dm_pc8;
    logic          empty;
    logic [CW-1:0] count;

    modport master (
        output st_valid, st_addr, st_data, st_pc8, ld_valid, ld_addr, drain_ok,
        input  st_ready, ld_fwd, ld_data, ld_stall, dm_we, dm_addr, dm_data,
               dm_pc8, empty, count
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_pc8, ld_valid, ld_addr, drain_ok,
        output st_ready, ld_fwd, ld_data, ld_stall, dm_we, dm_addr, dm_data,
               dm_pc8, empty, count
    );

endinterface

`default_nettype wire

// File: rtl/sb_match.sv
// ============================================================================
// Module      : sb_match
// Description : DEPTH-way address comparator. Reports whether any valid entry
//               matches the key and the index of the youngest such entry,
//               where age is measured backwards from the tail pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_match
    import mips_mem_pkg::*;
#(
    parameter  int DEPTH = SB_DEPTH,
    parameter  int AW    = DM_AW,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]         valid,
    input  logic [DEPTH-1:0][AW-1:0] addr,
    input  logic [PW-1:0]            tail,
    input  logic [AW-1:0]            key,
    output logic                     hit,
    output logic [PW-1:0]            idx
);

    // Walk oldest (tail-DEPTH) to youngest (tail-1); a later match overrides, so the youngest wins.
    always_comb begin
        logic [PW-1:0] j;
        hit = 1'b0;
        idx = '0;
        j   = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            j = tail - PW'(k);
            if (valid[j] && (addr[j] == key)) begin
                hit = 1'b1;
                idx = j;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dm_store_buffer.sv
// ============================================================================
// Module      : dm_store_buffer
// Description : In-order store buffer in front of the single-port data memory.
//               Queues MEM-stage stores, retires the oldest one whenever the
//               memory port is free, and resolves loads hitting pending stores.
//               Build option SB_FORWARD_EN: forward youngest matching data to
//               loads; when undefined, matching loads stall until drained.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_store_buffer
    import mips_mem_pkg::*;
#(
    parameter  int DEPTH = SB_DEPTH,
    parameter  int AW    = DM_AW,
    parameter  int DW    = mips_mem_pkg::DW,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    dm_store_buffer_if.slave  sb
);

    logic [DEPTH-1:0]         ent_valid;
    logic [DEPTH-1:0][AW-1:0] ent_addr;
    logic [DW-1:0]            ent_data [DEPTH];
    logic [31:0]              ent_pc8  [DEPTH];
    logic [PW-1:0]            head;
    logic [PW-1:0]            tail;
    logic [CW-1:0]            count;

    logic                     push;
    logic                     pop;
    logic                     hit;
    logic [PW-1:0]            hit_idx;

    // Ready is from the registered count only: a same-cycle pop never frees a slot for a push.
    assign sb.st_ready = (count != CW'(DEPTH));
    assign sb.empty    = (count == '0);
    assign sb.count    = count;
    assign push        = sb.st_valid && sb.st_ready;
    assign pop         = !sb.empty && sb.drain_ok && !reset;

    assign sb.dm_we    = pop;
    assign sb.dm_addr  = ent_addr[head];
    assign sb.dm_data  = ent_data[head];
    assign sb.dm_pc8   = ent_pc8[head];

    // FIFO state: push at tail, retire at head; reset discards every pending store.
    always_ff @(posedge clk) begin
        if (reset) begin
            ent_valid <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            if (push) begin
                ent_valid[tail] <= 1'b1;
                ent_addr[tail]  <= sb.st_addr;
                ent_data[tail]  <= sb.st_data;
                ent_pc8[tail]   <= sb.st_pc8;
                tail            <= tail + 1'b1;
            end
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Registered entries only: the store being pushed this cycle is not visible to the load.
    sb_match #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_match (
        .valid (ent_valid),
        .addr  (ent_addr),
        .tail  (tail),
        .key   (sb.ld_addr),
        .hit   (hit),
        .idx   (hit_idx)
    );

`ifdef SB_FORWARD_EN
    // Matching load takes the youngest pending data; never stalls.
    always_comb begin
        sb.ld_fwd   = sb.ld_valid && hit;
        sb.ld_data  = '0;
        sb.ld_stall = 1'b0;
        if (sb.ld_fwd) begin
            sb.ld_data = ent_data[hit_idx];
        end
    end
`else
    logic unused_hit_idx;
    assign unused_hit_idx = ^hit_idx;

    // No forwarding path: a matching load waits until the store has drained.
    always_comb begin
        sb.ld_fwd   = 1'b0;
        sb.ld_data  = '0;
        sb.ld_stall = sb.ld_valid && hit;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dm_store_buffer.sv
`default_nettype none

module tb_dm_store_buffer;
    import mips_mem_pkg::*;

    localparam int D = SB_DEPTH;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dm_store_buffer_if #(.DEPTH(D), .AW(DM_AW), .DW(DW)) sbif ();

    dm_store_buffer #(.DEPTH(D), .AW(DM_AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sbif.slave)
    );

    int        total = 0;
    int        bad   = 0;
    sb_entry_t q[$];
    bit        last_push;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check all outputs against the queue model before the edge, then advance the model.
    task automatic cyc(input bit do_chk);
        #1;
        if (do_chk) begin
            int             n;
            bit             hit;
            logic [DW-1:0]  hd;
            bit             exp_we;
            n      = q.size();
            hit    = 1'b0;
            hd     = '0;
            for (int i = 0; i < n; i++) begin
                if (q[i].addr == sbif.ld_addr) begin
                    hit = 1'b1;
                    hd  = q[i].data;
                end
            end
            exp_we = !reset && (n > 0) && sbif.drain_ok;
            chk("st_ready", 64'(sbif.st_ready), 64'(n < D));
            chk("empty",    64'(sbif.empty),    64'(n == 0));
            chk("count",    64'(sbif.count),    64'(n));
            chk("dm_we",    64'(sbif.dm_we),    64'(exp_we));
            if (exp_we) begin
                chk("dm_addr", 64'(sbif.dm_addr), 64'(q[0].addr));
                chk("dm_data", 64'(sbif.dm_data), 64'(q[0].data));
                chk("dm_pc8",  64'(sbif.dm_pc8),  64'(q[0].pc8));
            end
`ifdef SB_FORWARD_EN
            chk("ld_fwd",   64'(sbif.ld_fwd),   64'(sbif.ld_valid && hit));
            chk("ld_data",  64'(sbif.ld_data),  64'((sbif.ld_valid && hit) ? hd : '0));
            chk("ld_stall", 64'(sbif.ld_stall), 64'(0));
`else
            chk("ld_fwd",   64'(sbif.ld_fwd),   64'(0));
            chk("ld_data",  64'(sbif.ld_data),  64'(0));
            chk("ld_stall", 64'(sbif.ld_stall), 64'(sbif.ld_valid && hit));
`endif
        end
        @(posedge clk);
        last_push = 1'b0;
        if (reset) begin
            q.delete();
        end else begin
            bit        pop;
            bit        push;
            sb_entry_t e;
            pop  = (q.size() > 0) && sbif.drain_ok;
            push = sbif.st_valid && (q.size() < D);
            if (pop) void'(q.pop_front());
            if (push) begin
                e.valid = 1'b1;
                e.addr  = sbif.st_addr;
                e.data  = sbif.st_data;
                e.pc8   = sbif.st_pc8;
                q.push_back(e);
            end
            last_push = push;
        end
        @(negedge clk);
    endtask

    task automatic set_st(input bit v, input logic [DM_AW-1:0] a, input logic [DW-1:0] d);
        sbif.st_valid = v;
        sbif.st_addr  = a;
        sbif.st_data  = d;
        sbif.st_pc8   = $urandom;
    endtask

    initial begin
        reset          = 1'b1;
        sbif.ld_valid  = 1'b0;
        sbif.ld_addr   = '0;
        sbif.drain_ok  = 1'b0;
        set_st(1'b0, '0, '0);

        // Reset and idle
        cyc(1'b0);
        cyc(1'b1);
        reset = 1'b0;
        repeat (2) cyc(1'b1);

        // Single store held back, then drained
        set_st(1'b1, 10'h004, 32'hDEADBEEF);
        cyc(1'b1);
        set_st(1'b0, '0, '0);
        repeat (3) cyc(1'b1);
        sbif.drain_ok = 1'b1;
        repeat (2) cyc(1'b1);

        // Fill, reject a fifth store, then drain in order
        sbif.drain_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_st(1'b1, 10'(8 + i), 32'hA000_0000 + 32'(i));
            cyc(1'b1);
        end
        set_st(1'b1, 10'h0FF, 32'hBAD0BAD0);
        repeat (2) cyc(1'b1);
        set_st(1'b0, '0, '0);
        sbif.drain_ok = 1'b1;
        repeat (5) cyc(1'b1);

        // Two stores to one address, then a load of that address
        sbif.drain_ok = 1'b0;
        set_st(1'b1, 10'h010, 32'h11111111);
        cyc(1'b1);
        set_st(1'b1, 10'h010, 32'h22222222);
        cyc(1'b1);
        set_st(1'b0, '0, '0);
        sbif.ld_valid = 1'b1;
        sbif.ld_addr  = 10'h010;
        repeat (2) cyc(1'b1);
        sbif.drain_ok = 1'b1;
        repeat (3) cyc(1'b1);
        sbif.ld_valid = 1'b0;

        // Full buffer with continuous push and pop; pointers wrap
        sbif.drain_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_st(1'b1, 10'(32 + i), 32'hC000_0000 + 32'(i));
            cyc(1'b1);
        end
        sbif.drain_ok = 1'b1;
        begin
            int k;
            k = 4;
            set_st(1'b1, 10'(32 + k), 32'hC000_0000 + 32'(k));
            for (int i = 0; i < 8; i++) begin
                cyc(1'b1);
                if (last_push) begin
                    k++;
                    set_st(1'b1, 10'(32 + k), 32'hC000_0000 + 32'(k));
                end
            end
        end
        set_st(1'b0, '0, '0);
        repeat (5) cyc(1'b1);

        // Reset with three pending stores while the port is free
        sbif.drain_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_st(1'b1, 10'(64 + i), 32'hE000_0000 + 32'(i));
            cyc(1'b1);
        end
        set_st(1'b0, '0, '0);
        sbif.drain_ok = 1'b1;
        reset = 1'b1;
        cyc(1'b1);
        reset = 1'b0;
        repeat (3) cyc(1'b1);

        // Random traffic over a small address set to provoke load matches
        for (int i = 0; i < 400; i++) begin
            set_st(($urandom_range(0, 9) < 6), 10'($urandom_range(0, 7)), $urandom);
            sbif.ld_valid = $urandom_range(0, 1);
            sbif.ld_addr  = 10'($urandom_range(0, 7));
            sbif.drain_ok = $urandom_range(0, 1);
            reset         = ($urandom_range(0, 99) == 0);
            cyc(1'b1);
        end
        reset = 1'b0;
        set_st(1'b0, '0, '0);
        sbif.ld_valid = 1'b0;
        sbif.drain_ok = 1'b1;
        repeat (5) cyc(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
